// File: rtl/array_reverse.sv
// In-place window reversal sequencer driving a valid/ready array memory port.
// Each swap is read i, read j, write i, write j; the swap count is returned on a result handshake.
module array_reverse #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_lo,
    input  logic [ADDR_W-1:0] in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_swaps,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do
);

    typedef enum logic [2:0] {
        StIdle,
        StRdI,
        StRdJ,
        StWrI,
        StWrJ,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0]   swaps_q, swaps_d;
    logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0]   tmp_b_q, tmp_b_d;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_swaps_q, out_swaps_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_di_q, mem_di_d;

    logic [ADDR_W-1:0]   half_len;
    logic                mem_acc;

    assign half_len = in_len >> 1;
    assign mem_acc  = mem_valid_q && mem_ready;

    // Next-state and datapath registers
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rem_d   = rem_q;
        swaps_d = swaps_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    i_d     = in_lo;
                    j_d     = in_lo + in_len - ADDR_W'(1);
                    rem_d   = half_len;
                    swaps_d = half_len;
                    state_d = (half_len == '0) ? StDone : StRdI;
                end
            end
            StRdI: begin
                if (mem_acc) begin
                    tmp_a_d = mem_do;
                    state_d = StRdJ;
                end
            end
            StRdJ: begin
                if (mem_acc) begin
                    tmp_b_d = mem_do;
                    state_d = StWrI;
                end
            end
            StWrI: begin
                if (mem_acc) begin
                    state_d = StWrJ;
                end
            end
            StWrJ: begin
                if (mem_acc) begin
                    i_d     = i_q + ADDR_W'(1);
                    j_d     = j_q - ADDR_W'(1);
                    rem_d   = rem_q - ADDR_W'(1);
                    state_d = (rem_q == ADDR_W'(1)) ? StDone : StRdI;
                end
            end
            StDone: begin
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, decoded from the state being entered
    always_comb begin
        in_ready_d  = (state_d == StIdle);
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_di_d    = '0;

        unique case (state_d)
            StRdI: begin
                mem_valid_d = 1'b1;
                mem_addr_d  = i_d;
            end
            StRdJ: begin
                mem_valid_d = 1'b1;
                mem_addr_d  = j_d;
            end
            StWrI: begin
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = i_d;
                mem_di_d    = tmp_b_d;
            end
            StWrJ: begin
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = j_d;
                mem_di_d    = tmp_a_d;
            end
            default: ;
        endcase

        // Zero-swap commands sit one cycle in DONE before presenting the result
        out_valid_d = (state_d == StDone) && (state_q != StIdle);
        out_swaps_d = out_valid_d ? swaps_d : '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            rem_q       <= '0;
            swaps_q     <= '0;
            tmp_a_q     <= '0;
            tmp_b_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_swaps_q <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_di_q    <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rem_q       <= rem_d;
            swaps_q     <= swaps_d;
            tmp_a_q     <= tmp_a_d;
            tmp_b_q     <= tmp_b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_swaps_q <= out_swaps_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_di_q    <= mem_di_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_swaps = out_swaps_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_di    = mem_di_q;

endmodule

// File: tb/tb_array_reverse.sv
// Bench for array_reverse: 16-entry array memory, 4-bit addresses so windows can wrap.
// An access-order model built per command is compared against every accepted memory transfer.
module tb_array_reverse;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_lo;
    logic [AW-1:0] in_len;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_swaps;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do;

    always #5 clk = ~clk;

    array_reverse #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lo     (in_lo),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_swaps (out_swaps),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .mem_do    (mem_do)
    );

    // Array memory attached to the DUT
    logic [DW-1:0] mem [N];
    logic          init_req;
    assign mem_do = mem[mem_addr];

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < N; k++) mem[k] <= DW'(k);
        end else if (mem_valid && mem_ready && mem_we) begin
            mem[mem_addr] <= mem_di;
        end
    end

    typedef struct {
        int   addr;
        logic we;
        int   di;
    } op_t;

    op_t           exp_q[$];
    int            log_q[$];
    logic [DW-1:0] model_mem [N];
    logic [DW-1:0] snap [N];
    logic [N-1:0]  seen;
    int            stall_cnt;
    int            n_checks = 0;
    int            n_errors = 0;

    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [DW-1:0] prev_di;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Per-cycle compare against the expected access sequence
    always @(negedge clk) begin
        if (!nrst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_exclusive", 64'(in_ready && (mem_valid || out_valid)), 64'd0);
            if (mem_valid && prev_stall)
                check("stall_hold", {mem_addr, mem_we, mem_di}, {prev_addr, prev_we, prev_di});
            if (mem_valid && mem_ready) begin
                seen[mem_addr] = 1'b1;
                log_q.push_back(mem_we ? 1000 + 100 * int'(mem_addr) + int'(mem_di)
                                       : int'(mem_addr));
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_access: addr %0d we %0b", mem_addr, mem_we);
                end else begin
                    op_t e;
                    e = exp_q.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("mem_we", 64'(mem_we), 64'(e.we));
                    if (e.we) check("mem_di", 64'(mem_di), 64'(e.di));
                end
            end
            if (mem_valid && !mem_ready) stall_cnt++;
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_di    = mem_di;
        end
    end

    task automatic init_mem();
        init_req = 1'b1;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        for (int k = 0; k < N; k++) model_mem[k] = DW'(k);
    endtask

    // Expected transfers of a reversal, applied to the model array
    task automatic build(input int lo, input int len);
        int s;
        int a;
        int b;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        s = len / 2;
        for (int k = 0; k < s; k++) begin
            a  = (lo + k) % N;
            b  = (lo + len - 1 - k) % N;
            da = model_mem[a];
            db = model_mem[b];
            exp_q.push_back('{addr: a, we: 1'b0, di: 0});
            exp_q.push_back('{addr: b, we: 1'b0, di: 0});
            exp_q.push_back('{addr: a, we: 1'b1, di: int'(db)});
            exp_q.push_back('{addr: b, we: 1'b1, di: int'(da)});
            model_mem[a] = db;
            model_mem[b] = da;
        end
    endtask

    task automatic check_mem();
        for (int k = 0; k < N; k++) check($sformatf("mem[%0d]", k), mem[k], model_mem[k]);
    endtask

    task automatic run_cmd(input int lo, input int len, input bit rnd, input bit keep_valid,
                           input int hold, output int lat);
        int s;
        int cyc;
        s = len / 2;
        build(lo, len);
        stall_cnt = 0;
        seen      = '0;
        log_q.delete();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_lo    = AW'(lo);
        in_len   = AW'(len);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (keep_valid) begin
            in_lo  = '0;
            in_len = 4'd15;
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        while (!out_valid && cyc < 500) begin
            if (rnd) mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        lat       = cyc;
        check("result_arrives", 64'(out_valid), 64'd1);
        check("latency", 64'(cyc), 64'(((s == 0) ? 1 : 4 * s) + stall_cnt));
        check("out_swaps", 64'(out_swaps), 64'(s));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_swaps", 64'(out_swaps), 64'(s));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int exp_log [12];
        int cyc;
        exp_log = '{2, 7, 1207, 1702, 3, 6, 1306, 1603, 4, 5, 1405, 1504};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_lo     = '0;
        in_len    = '0;
        out_ready = 1'b0;
        mem_ready = 1'b1;
        init_req  = 1'b0;
        init_mem();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_di", 64'(mem_di), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_swaps", 64'(out_swaps), 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        // lo=2 len=6
        run_cmd(2, 6, 1'b0, 1'b0, 0, lat);
        check("t1_latency", 64'(lat), 64'd12);
        check("t1_log_len", 64'(log_q.size()), 64'd12);
        for (int k = 0; k < 12 && k < log_q.size(); k++)
            check($sformatf("t1_access%0d", k), 64'(log_q[k]), 64'(exp_log[k]));
        for (int k = 0; k < N; k++)
            check($sformatf("t1_mem[%0d]", k), mem[k],
                  DW'((k >= 2 && k <= 7) ? 9 - k : k));
        check_mem();

        // Odd length: middle untouched
        init_mem();
        run_cmd(0, 5, 1'b0, 1'b0, 0, lat);
        check("t2_latency", 64'(lat), 64'd8);
        for (int k = 0; k < 5; k++) check($sformatf("t2_mem[%0d]", k), mem[k], DW'(4 - k));
        check("t2_mid_unseen", 64'(seen[2]), 64'd0);
        check_mem();

        // Zero-swap commands
        run_cmd(5, 0, 1'b0, 1'b0, 0, lat);
        check("t3_len0_latency", 64'(lat), 64'd1);
        check("t3_len0_noaccess", 64'(log_q.size()), 64'd0);
        run_cmd(9, 1, 1'b0, 1'b0, 0, lat);
        check("t3_len1_latency", 64'(lat), 64'd1);
        check("t3_len1_noaccess", 64'(log_q.size()), 64'd0);

        // Random stalls with in_valid held high during the operation
        init_mem();
        run_cmd(8, 8, 1'b1, 1'b1, 0, lat);
        for (int k = 8; k < 16; k++) check($sformatf("t4_mem[%0d]", k), mem[k], DW'(23 - k));
        check_mem();

        // Address wrap plus result back-pressure
        init_mem();
        run_cmd(14, 4, 1'b0, 1'b0, 5, lat);
        check("t5_latency", 64'(lat), 64'd8);
        check("t5_mem14", mem[14], 32'd1);
        check("t5_mem1", mem[1], 32'd14);
        check("t5_mem15", mem[15], 32'd0);
        check("t5_mem0", mem[0], 32'd15);
        check_mem();

        // Reset during the first write of a swap
        init_mem();
        snap = model_mem;
        build(0, 4);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_lo    = '0;
        in_len   = 4'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!(mem_valid && mem_we) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t6_in_wr_i", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b1, 4'd0});
        #2;
        nrst = 1'b0;
        #1;
        check("t6_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_mem_we", 64'(mem_we), 64'd0);
        exp_q.delete();
        model_mem = snap;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_mem_valid", 64'(mem_valid), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check_mem();

        // Recovery after reset
        run_cmd(1, 3, 1'b0, 1'b0, 0, lat);
        check("t7_latency", 64'(lat), 64'd4);
        check("t7_mem1", mem[1], 32'd3);
        check("t7_mem3", mem[3], 32'd1);
        check_mem();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
